// File: rtl/iter_cmp_unit_pkg.sv
// Shared encodings for the iterative compare/branch-condition unit.
package iter_cmp_unit_pkg;

  localparam int CmpOut_LEN = 2;

  typedef enum logic [CmpOut_LEN-1:0] {
    CMP_UNDEF   = 2'b00,
    CMP_LESS    = 2'b01,
    CMP_EQ      = 2'b10,
    CMP_GREATER = 2'b11
  } cmp_out_e;

  typedef enum logic [2:0] {
    CMPOP_CMPU = 3'd0,
    CMPOP_CMPS = 3'd1,
    CMPOP_BEQ  = 3'd2,
    CMPOP_BNE  = 3'd3,
    CMPOP_BLEZ = 3'd4,
    CMPOP_BGTZ = 3'd5,
    CMPOP_BLTZ = 3'd6,
    CMPOP_BGEZ = 3'd7
  } cmp_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Zero-compare branches ignore operand B.
  function automatic logic is_zero_op(cmp_op_e op);
    return op inside {CMPOP_BLEZ, CMPOP_BGTZ, CMPOP_BLTZ, CMPOP_BGEZ};
  endfunction

  function automatic logic br_eval(cmp_op_e op, cmp_out_e r);
    case (op)
      CMPOP_BEQ:  return r == CMP_EQ;
      CMPOP_BNE:  return r != CMP_EQ;
      CMPOP_BLEZ: return (r == CMP_LESS) || (r == CMP_EQ);
      CMPOP_BGTZ: return r == CMP_GREATER;
      CMPOP_BLTZ: return r == CMP_LESS;
      CMPOP_BGEZ: return (r == CMP_GREATER) || (r == CMP_EQ);
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/iter_cmp_unit_cmp_slice.sv
// One slice of the magnitude compare; invert_msb turns unsigned ordering into
// two's-complement ordering for the top slice.
module cmp_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             invert_msb,
  output logic             lt,
  output logic             eq
);

  logic [SLICE-1:0] flip;
  logic [SLICE-1:0] a_x;
  logic [SLICE-1:0] b_x;

  assign flip = SLICE'(invert_msb) << (SLICE - 1);
  assign a_x  = a ^ flip;
  assign b_x  = b ^ flip;
  assign lt   = a_x < b_x;
  assign eq   = a == b;

endmodule

// File: rtl/iter_cmp_unit.sv
// Multi-cycle MSB-first compare with early exit, plus MIPS branch-condition decode.
module iter_cmp_unit
  import iter_cmp_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [1:0]       cmp_out,
  output logic             br_taken,
  output logic             sign_ge0
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % SLICE != 0) begin : g_bad_width
    $error("iter_cmp_unit: WIDTH must be a multiple of SLICE");
  end

  state_e                   state_q, state_d;
  logic [N-1:0][SLICE-1:0]  a_q, a_d, b_q, b_d;
  cmp_op_e                  op_q, op_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     done_q, done_d;
  cmp_out_e                 cmp_q, cmp_d;
  logic                     br_q, br_d;
  logic                     sge_q, sge_d;

  logic                     accept, last;
  logic [IW-1:0]            sel;
  logic                     sl_lt, sl_eq;

  assign accept = (state_q == ST_IDLE) && start && !flush;
  assign last   = idx_q == IW'(N - 1);
  // idx 0 addresses the most significant slice.
  assign sel    = IW'(N - 1) - idx_q;

  cmp_slice #(.SLICE(SLICE)) u_slice (
    .a          (a_q[sel]),
    .b          (b_q[sel]),
    .invert_msb ((op_q != CMPOP_CMPU) && (idx_q == '0)),
    .lt         (sl_lt),
    .eq         (sl_eq)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (flush || !sl_eq || last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = state_q == ST_RUN;
  end

  // Datapath: operand latches, slice index and the registered result.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    idx_d  = idx_q;
    done_d = 1'b0;
    cmp_d  = cmp_q;
    br_d   = br_q;
    sge_d  = sge_q;
    if (accept) begin
      a_d   = data_a;
      op_d  = cmp_op_e'(op);
      b_d   = is_zero_op(cmp_op_e'(op)) ? '0 : data_b;
      idx_d = '0;
    end else if (state_q == ST_RUN && !flush) begin
      if (!sl_eq || last) begin
        done_d = 1'b1;
        cmp_d  = !sl_eq ? (sl_lt ? CMP_LESS : CMP_GREATER) : CMP_EQ;
        br_d   = br_eval(op_q, cmp_d);
        sge_d  = ~a_q[N-1][SLICE-1];
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= CMPOP_CMPU;
      idx_q  <= '0;
      done_q <= 1'b0;
      cmp_q  <= CMP_UNDEF;
      br_q   <= 1'b0;
      sge_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      idx_q  <= idx_d;
      done_q <= done_d;
      cmp_q  <= cmp_d;
      br_q   <= br_d;
      sge_q  <= sge_d;
    end
  end

  assign done     = done_q;
  assign cmp_out  = cmp_q;
  assign br_taken = br_q;
  assign sign_ge0 = sge_q;

endmodule

// File: tb/tb_iter_cmp_unit.sv
// Directed bench for iter_cmp_unit: 32/8 instance plus a 32/32 single-slice instance.
module tb_iter_cmp_unit;

  localparam logic [1:0] UNDEF = 2'b00, LESS = 2'b01, EQ = 2'b10, GREATER = 2'b11;
  localparam logic [2:0] CMPU = 3'd0, CMPS = 3'd1, BEQ = 3'd2, BNE = 3'd3,
                         BLEZ = 3'd4, BGTZ = 3'd5, BLTZ = 3'd6, BGEZ = 3'd7;

  logic        clk = 1'b0;
  logic        reset, start, start32, flush;
  logic [2:0]  op;
  logic [31:0] data_a, data_b;
  logic        busy, done, br_taken, sign_ge0;
  logic [1:0]  cmp_out;
  logic        busy32, done32, br_taken32, sign_ge032;
  logic [1:0]  cmp_out32;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [1:0]  cmp;
    logic        br;
    logic        sge;
  } vec_t;

  always #5 clk = ~clk;

  iter_cmp_unit #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
    .data_a(data_a), .data_b(data_b), .busy(busy), .done(done),
    .cmp_out(cmp_out), .br_taken(br_taken), .sign_ge0(sign_ge0)
  );

  iter_cmp_unit #(.WIDTH(32), .SLICE(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .flush(flush), .op(op),
    .data_a(data_a), .data_b(data_b), .busy(busy32), .done(done32),
    .cmp_out(cmp_out32), .br_taken(br_taken32), .sign_ge0(sign_ge032)
  );

  // Issue one request and return edges from accept to done (-1 if none within budget).
  task automatic run_op(input bit wide, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    @(negedge clk);
    op = o; data_a = a; data_b = b;
    if (wide) start32 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start32 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if ((wide ? done32 : done) === 1'b1) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start32 = 1'b0; flush = 1'b0;
    op = CMPU; data_a = '0; data_b = '0;
    #12;
    checks++;
    if ({busy, done, cmp_out, br_taken, sign_ge0} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 000000", {busy, done, cmp_out, br_taken, sign_ge0});
    end
    checks++;
    if ({busy32, done32, cmp_out32, br_taken32, sign_ge032} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs32: got %b want 000000",
               {busy32, done32, cmp_out32, br_taken32, sign_ge032});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_vectors();
    vec_t v[12];
    int lat;
    v[0]  = '{CMPU, 32'h80000000, 32'h00000001, 1, GREATER, 1'b0, 1'b0};
    v[1]  = '{CMPS, 32'h80000000, 32'h00000001, 1, LESS,    1'b0, 1'b0};
    v[2]  = '{BNE,  32'h00000010, 32'h00000011, 4, LESS,    1'b1, 1'b1};
    v[3]  = '{BEQ,  32'h12345678, 32'h12345678, 4, EQ,      1'b1, 1'b1};
    v[4]  = '{BLEZ, 32'h00000000, 32'hFFFFFFFF, 4, EQ,      1'b1, 1'b1};
    v[5]  = '{BGTZ, 32'hFFFFFFFF, 32'h00000000, 1, LESS,    1'b0, 1'b0};
    v[6]  = '{BLTZ, 32'hFFFFFFFF, 32'h12345678, 1, LESS,    1'b1, 1'b0};
    v[7]  = '{BGEZ, 32'h00000100, 32'hFFFFFFFF, 3, GREATER, 1'b1, 1'b1};
    v[8]  = '{CMPU, 32'h12345678, 32'h12345679, 4, LESS,    1'b0, 1'b1};
    v[9]  = '{CMPS, 32'h7FFFFFFF, 32'h80000000, 1, GREATER, 1'b0, 1'b1};
    v[10] = '{BNE,  32'h00000005, 32'h00000005, 4, EQ,      1'b0, 1'b1};
    v[11] = '{BGTZ, 32'h00000001, 32'h80000000, 4, GREATER, 1'b1, 1'b1};
    for (int i = 0; i < 12; i++) begin
      run_op(1'b0, v[i].op, v[i].a, v[i].b, lat);
      checks++;
      if (lat != v[i].lat || cmp_out !== v[i].cmp || br_taken !== v[i].br || sign_ge0 !== v[i].sge) begin
        failures++;
        $display("FAIL vec%0d: got lat=%0d cmp=%b br=%b sge=%b want lat=%0d cmp=%b br=%b sge=%b",
                 i, lat, cmp_out, br_taken, sign_ge0, v[i].lat, v[i].cmp, v[i].br, v[i].sge);
      end
    end
  endtask

  task automatic test_flush();
    int lat;
    bit seen;
    run_op(1'b0, CMPU, 32'h80000000, 32'h00000001, lat);
    @(negedge clk);
    op = BEQ; data_a = 32'h00000001; data_b = 32'h00000001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL flush_run: got busy=%b done=%b want busy=0 done=0", busy, done);
    end
    checks++;
    if (cmp_out !== GREATER || br_taken !== 1'b0 || sign_ge0 !== 1'b0) begin
      failures++;
      $display("FAIL flush_hold: got cmp=%b br=%b sge=%b want cmp=11 br=0 sge=0",
               cmp_out, br_taken, sign_ge0);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL flush_no_done: got done pulse=1 want 0");
    end
    @(negedge clk);
    op = CMPU; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_busy_ignore();
    int first, ndone;
    @(negedge clk);
    op = BEQ; data_a = 32'hCAFEF00D; data_b = 32'hCAFEF00D; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first = -1; ndone = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      start = (i == 1);
      if (i == 1) begin op = CMPU; data_a = 32'h80000000; data_b = 32'h00000001; end
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (first != 4 || ndone != 1) begin
      failures++;
      $display("FAIL busy_ignore: got first_done=%0d count=%0d want 4 and 1", first, ndone);
    end
    checks++;
    if (cmp_out !== EQ || br_taken !== 1'b1 || sign_ge0 !== 1'b0) begin
      failures++;
      $display("FAIL busy_ignore_result: got cmp=%b br=%b sge=%b want cmp=10 br=1 sge=0",
               cmp_out, br_taken, sign_ge0);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    op = BEQ; data_a = 32'h01010101; data_b = 32'h01010101; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, cmp_out, br_taken, sign_ge0} !== 6'b0) begin
      failures++;
      $display("FAIL async_reset: got %b want 000000", {busy, done, cmp_out, br_taken, sign_ge0});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    op = CMPU; data_a = 32'h80000000; data_b = 32'h00000001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || cmp_out !== GREATER) begin
      failures++;
      $display("FAIL b2b_first: got done=%b cmp=%b want done=1 cmp=11", done, cmp_out);
    end
    op = CMPS; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: got busy=%b want 1", busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || cmp_out !== LESS) begin
      failures++;
      $display("FAIL b2b_second: got done=%b cmp=%b want done=1 cmp=01", done, cmp_out);
    end
  endtask

  task automatic test_slice32();
    vec_t v[4];
    int lat;
    v[0] = '{CMPU, 32'h00000010, 32'h00000011, 1, LESS,    1'b0, 1'b1};
    v[1] = '{BEQ,  32'h12345678, 32'h12345678, 1, EQ,      1'b1, 1'b1};
    v[2] = '{CMPS, 32'h80000000, 32'h00000001, 1, LESS,    1'b0, 1'b0};
    v[3] = '{BGEZ, 32'h00000100, 32'hFFFFFFFF, 1, GREATER, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, v[i].op, v[i].a, v[i].b, lat);
      checks++;
      if (lat != v[i].lat || cmp_out32 !== v[i].cmp || br_taken32 !== v[i].br || sign_ge032 !== v[i].sge) begin
        failures++;
        $display("FAIL s32_vec%0d: got lat=%0d cmp=%b br=%b sge=%b want lat=%0d cmp=%b br=%b sge=%b",
                 i, lat, cmp_out32, br_taken32, sign_ge032, v[i].lat, v[i].cmp, v[i].br, v[i].sge);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_flush();
    test_busy_ignore();
    test_async_reset();
    test_back_to_back();
    test_slice32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
